// File: rtl/expr_pkg.sv
// Shared definitions for the arithmetic-expression character stream:
// FSM state encoding, operator codes and the ASCII characters used on the wire.
package expr_pkg;

   typedef enum logic [3:0] {
      StIdle = 4'b0001,
      StDig  = 4'b0010,
      StOp   = 4'b0100,
      StTerm = 4'b1000
   } expr_state_e;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_9     = 8'h39;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_STAR  = 8'h2A;
   localparam logic [7:0] ASCII_SLASH = 8'h2F;
   localparam logic [7:0] ASCII_EQ    = 8'h3D;

endpackage

// File: rtl/expr_char_enc.sv
// Combinational character encoder: BCD digit or 2-bit operator code to ASCII.
// Digits above 9 saturate to "9" and raise bad_digit.
module expr_char_enc
   import expr_pkg::*;
(
   input  logic       is_op,
   input  logic [3:0] code,
   output logic [7:0] ascii,
   output logic       bad_digit
);

   always_comb begin
      ascii     = ASCII_0;
      bad_digit = 1'b0;
      if (is_op) begin
         unique case (code[1:0])
            OP_ADD:  ascii = ASCII_PLUS;
            OP_SUB:  ascii = ASCII_MINUS;
            OP_MUL:  ascii = ASCII_STAR;
            OP_DIV:  ascii = ASCII_SLASH;
            default: ascii = ASCII_PLUS;
         endcase
      end else if (code > 4'd9) begin
         ascii     = ASCII_9;
         bad_digit = 1'b1;
      end else begin
         ascii = ASCII_0 + {4'h0, code};
      end
   end

endmodule

// File: rtl/expr_emit.sv
// Serialises a frame descriptor as "d op d ... d" ASCII over a valid/ready handshake.
// Define EXPR_EMIT_TERM_EN to append a trailing "=" that carries ch_last.
module expr_emit
   import expr_pkg::*;
#(
   parameter  int unsigned MAX_OPS = 8,
   localparam int unsigned LW      = $clog2(MAX_OPS + 1)
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 start,
   input  logic [LW-1:0]        len,
   input  logic [4*MAX_OPS-1:0] digits,
   input  logic [2*MAX_OPS-1:0] ops,
   output logic [7:0]           ch,
   output logic                 ch_valid,
   input  logic                 ch_ready,
   output logic                 ch_last,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   expr_state_e          state_q, state_d;
   logic [LW-1:0]        idx_q, idx_d;
   logic [LW-1:0]        len_q, len_d;
   logic [4*MAX_OPS-1:0] digits_q, digits_d;
   logic [2*MAX_OPS-1:0] ops_q, ops_d;
   logic [7:0]           ch_q, ch_d;
   logic                 ch_valid_q, ch_valid_d;
   logic                 ch_last_q, ch_last_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   logic          hs;
   logic          last_idx;
   logic [LW-1:0] len_clamp;
   logic          load_char;
   logic          frame_end;
   logic          err_clr;
   logic          enc_is_op;
   logic [3:0]    enc_code;
   logic [3:0]    sel_dig;
   logic [1:0]    sel_op;
   logic [7:0]    enc_ascii;
   logic          enc_bad;

   assign hs        = ch_valid_q & ch_ready;
   assign last_idx  = (idx_q == len_q - LW'(1));
   assign len_clamp = (len > LW'(MAX_OPS)) ? LW'(MAX_OPS) : len;

   // Sequencing: load_char means a new character is presented next cycle.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      digits_d  = digits_q;
      ops_d     = ops_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      load_char = 1'b0;
      frame_end = 1'b0;
      err_clr   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               len_d    = len_clamp;
               digits_d = digits;
               ops_d    = ops;
               idx_d    = '0;
               err_clr  = 1'b1;
               if (len_clamp == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = StDig;
                  busy_d    = 1'b1;
                  load_char = 1'b1;
               end
            end
         end
         StDig: begin
            if (hs) begin
               if (last_idx) begin
`ifdef EXPR_EMIT_TERM_EN
                  state_d   = StTerm;
                  load_char = 1'b1;
`else
                  state_d   = StIdle;
                  frame_end = 1'b1;
`endif
               end else begin
                  state_d   = StOp;
                  load_char = 1'b1;
               end
            end
         end
         StOp: begin
            if (hs) begin
               idx_d     = idx_q + LW'(1);
               state_d   = StDig;
               load_char = 1'b1;
            end
         end
`ifdef EXPR_EMIT_TERM_EN
         StTerm: begin
            if (hs) begin
               state_d   = StIdle;
               frame_end = 1'b1;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
      if (frame_end) begin
         busy_d = 1'b0;
         done_d = 1'b1;
      end
   end

   // Encoder looks at the next-cycle slot so ch is registered without a bubble.
   always_comb begin
      sel_dig = '0;
      sel_op  = '0;
      for (int unsigned i = 0; i < MAX_OPS; i++) begin
         if (idx_d == LW'(i)) begin
            sel_dig = digits_d[4*i +: 4];
            sel_op  = ops_d[2*i +: 2];
         end
      end
      enc_is_op = (state_d == StOp);
      enc_code  = enc_is_op ? {2'b00, sel_op} : sel_dig;
   end

   expr_char_enc u_enc (
      .is_op     (enc_is_op),
      .code      (enc_code),
      .ascii     (enc_ascii),
      .bad_digit (enc_bad)
   );

   always_comb begin
      ch_d       = ch_q;
      ch_valid_d = ch_valid_q;
      ch_last_d  = ch_last_q;
      err_d      = err_clr ? 1'b0 : err_q;
      if (load_char) begin
         ch_valid_d = 1'b1;
         ch_d       = enc_ascii;
         ch_last_d  = 1'b0;
         if (state_d == StDig) begin
            err_d = err_d | enc_bad;
`ifndef EXPR_EMIT_TERM_EN
            ch_last_d = (idx_d == len_d - LW'(1));
`endif
         end
`ifdef EXPR_EMIT_TERM_EN
         if (state_d == StTerm) begin
            ch_d      = ASCII_EQ;
            ch_last_d = 1'b1;
         end
`endif
      end else if (frame_end) begin
         ch_d       = '0;
         ch_valid_d = 1'b0;
         ch_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         len_q      <= '0;
         digits_q   <= '0;
         ops_q      <= '0;
         ch_q       <= '0;
         ch_valid_q <= 1'b0;
         ch_last_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         digits_q   <= digits_d;
         ops_q      <= ops_d;
         ch_q       <= ch_d;
         ch_valid_q <= ch_valid_d;
         ch_last_q  <= ch_last_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign ch       = ch_q;
   assign ch_valid = ch_valid_q;
   assign ch_last  = ch_last_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: doc/expr_emit.md
# expr_emit

Transmitter for the team's arithmetic-expression character stream. It takes a frame descriptor (operand count, BCD operand digits, 2-bit operator codes) and serialises it as ASCII: digit, operator, digit, …, digit. Characters go out one at a time over a valid/ready handshake. The block drives the expression recognizer and other character-stream consumers; every frame without invalid digits is a well-formed single-digit expression.

## Interface
- MAX_OPS, 8, maximum operands per frame (≥2)
- LW, $clog2(MAX_OPS+1), width of len (derived; do not override)
- clk  in  1  clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- start  in  1  frame request; sampled only while busy=0
- len  in  LW  operand count, 0..MAX_OPS (values >MAX_OPS clamp to MAX_OPS)
- digits  in  4*MAX_OPS  BCD operands; digits[4i+3:4i] is operand i
- ops  in  2*MAX_OPS  operator codes; ops[2i+1:2i] sits between operand i and i+1 (top slot unused)
- ch  out  8  ASCII character
- ch_valid  out  1  ch is valid
- ch_ready  in  1  consumer accepts ch this cycle
- ch_last  out  1  ch is the final character of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last character is accepted
- err  out  1  sticky: a digit >9 was encountered this frame

## Operation
- Reset values: ch=8'h00, ch_valid=0, ch_last=0, busy=0, done=0, err=0. State is IDLE.
- States (one-hot): IDLE, DIG, OP, TERM.
- Start handling in IDLE:
  - start=1 latches len, digits and ops into internal registers.
  - Clears err and the operand index. Sets busy=1.
  - Goes to DIG, or to IDLE with done=1 if len=0.
- DIG:
  - Presents "0"+digits[idx], with ch_valid=1.
  - On handshake (ch_valid & ch_ready):
    - If idx==len-1, go to TERM when EXPR_EMIT_TERM_EN is defined; otherwise go to IDLE and pulse done.
    - Else go to OP.
- OP:
  - Presents the operator character, with ch_valid=1.
  - Operator codes: 00 "+", 01 "-", 10 "*", 11 "/".
  - On handshake, increment idx and go to DIG.
- TERM: presents "=". On handshake, go to IDLE and pulse done.
- ch_last is 1 on the final character only: the last digit, or "=" when the terminator is compiled in.
- Invalid BCD digit (>9): emit "9" and set err. The frame continues. err holds until the next accepted start or clr.
- Characters per frame: 2*len-1, plus 1 when the terminator is enabled.
- Latched inputs are used throughout the frame. Input changes after start do not affect the frame in flight.
- start while busy=1 is ignored and not queued.

## Timing
- start sampled high at edge T (state IDLE): ch_valid=1 with the first digit from T+1.
- ch, ch_valid and ch_last are registered. They must not change while ch_valid=1 and ch_ready=0.
- With ch_ready tied high, one character is emitted per cycle with no bubbles between characters.
- Final handshake at edge E:
  - done=1, busy=0 and ch_valid=0 during cycle E+1.
  - A start in cycle E+1 is accepted, so the minimum frame-to-frame gap is 1 idle cycle.
- len=0 at edge T: done=1 and busy=0 in cycle T+1. No characters are emitted.
- clr asserted mid-frame: all outputs return to reset values immediately (asynchronous). The partial frame is abandoned and no done is issued.
- ch_ready while ch_valid=0 has no effect.

## Configuration
- EXPR_EMIT_TERM_EN defined:
  - Each frame ends with an extra "=" character (TERM state).
  - ch_last moves to that character.
- Undefined:
  - TERM state and its logic are compiled out.
  - The frame ends at the last digit, which carries ch_last.

## Structure
- Shared package expr_pkg holds:
  - the one-hot state constants (IDLE/DIG/OP/TERM);
  - the operator code localparams (OP_ADD=2'b00, OP_SUB, OP_MUL, OP_DIV);
  - the ASCII constants "0", "9", "+", "-", "*", "/", "=".
- The recognizer shares the same package.
- One sub-module, expr_char_enc:
  - combinational, converts {is_op, code[3:0]} to ASCII;
  - also outputs the bad_digit flag.
- Top level holds the FSM, the index counter, the input latches and the handshake.

## Test plan
- len=3, digits 1,2,3, ops "+","*", ch_ready=1:
  - stream "1","+","2","*","3" on consecutive cycles;
  - ch_last on "3"; done one cycle later; err=0.
- Same frame with ch_ready toggling 1,0,0,1,…: ch held stable during stalls, same 5-character stream, no duplicates.
- len=1, digit 7: single "7" with ch_last=1. len=0: done at T+1 and no ch_valid.
- len=2, digit0=4'hC: emit "9","-",… with err=1 through the end of the frame. err clears on the next start.
- clr pulsed after the 2nd character of a 4-operand frame: outputs zero immediately, no done. A fresh frame afterwards emits from operand 0.
- With EXPR_EMIT_TERM_EN, len=2, digits 5,6, op "/": stream "5","/","6","=", with ch_last only on "=".
